// File: rtl/ghost_sched_pkg.sv
// Shared types and timing constants for the ghost mode scheduler.
// All constants are width-matched to the counters that use them.
package ghost_sched_pkg;

    typedef enum logic [1:0] {
        G_WAIT    = 2'd0,
        G_SCATTER = 2'd1,
        G_CHASE   = 2'd2
    } global_mode_t;

    typedef enum logic [2:0] {
        HOUSE   = 3'd0,
        SCATTER = 3'd1,
        CHASE   = 3'd2,
        FRIGHT  = 3'd3,
        DEAD    = 3'd4
    } ghost_mode_t;

    localparam int          FPS         = 60;
    localparam logic [5:0]  LAST_FRAME  = 6'(FPS - 1);
    localparam logic [7:0]  SCAT_S_A    = 8'd7;
    localparam logic [7:0]  SCAT_S_B    = 8'd5;
    localparam logic [7:0]  CHASE_S     = 8'd20;
    localparam logic [3:0]  FRIGHT_S    = 4'd10;
    localparam logic [3:0]  FLASH_S     = 4'd5;
    localparam logic [7:0]  INKY_DOTS   = 8'd30;
    localparam logic [7:0]  CLYDE_DOTS  = 8'd60;
    localparam logic [7:0]  IDLE_FRAMES = 8'd240;
    localparam logic [10:0] BASE_PTS    = 11'd200;
    localparam logic [10:0] MAX_PTS     = 11'd1600;

endpackage

// File: rtl/ghost_sched_release_ctrl.sv
// Ghost-house release order: level start, dot thresholds and idle timeout.
// Emits at most one one-hot release per frame, lowest index first.
module ghost_release_ctrl
    import ghost_sched_pkg::*;
(
    input  logic       frame_clk,
    input  logic       clr_all,
    input  logic       clr_life,
    input  logic       level_start,
    input  logic       pellet_eaten,
    output logic [3:0] ghost_release
);

    logic       started;
    logic [3:0] released;
    logic [7:0] dots;
    logic [7:0] idle;
    logic [3:0] elig;
    logic [3:0] cand;
    logic       force_rel;

    always_comb begin
        force_rel = started && !pellet_eaten && (idle == IDLE_FRAMES - 8'd1);
        elig[0]   = started || level_start;
        elig[1]   = started;
        elig[2]   = started && (dots >= INKY_DOTS);
        elig[3]   = started && (dots >= CLYDE_DOTS);
        cand      = ~released & (elig | {4{force_rel}});
        // isolate lowest set bit
        ghost_release = cand & (~cand + 4'd1);
    end

    always_ff @(posedge frame_clk) begin
        if (clr_all || clr_life) begin
            started  <= 1'b0;
            released <= 4'b0;
            idle     <= 8'd0;
            if (clr_all)
                dots <= 8'd0;
        end else begin
            started  <= started | level_start;
            released <= released | ghost_release;
            if (pellet_eaten && dots != 8'hFF)
                dots <= dots + 8'd1;
            if (!started || pellet_eaten || force_rel)
                idle <= 8'd0;
            else
                idle <= idle + 8'd1;
        end
    end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global scatter/chase timetable, frightened timer, per-ghost modes
// and eaten-ghost score combo for the four ghosts.
module ghost_mode_scheduler
    import ghost_sched_pkg::*;
(
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        new_map,
    input  logic        soft_reset,
    input  logic        level_start,
    input  logic        pellet_eaten,
    input  logic        power_pellet,
    input  logic [3:0]  ghost_eaten,
    input  logic [3:0]  ghost_home,
    output logic [1:0]  global_mode,
    output logic [11:0] ghost_mode,
    output logic        fright_flash,
    output logic [3:0]  reverse_req,
    output logic [11:0] score_add
);

    logic         clr_all;
    logic         clr_life;
    global_mode_t gm_q, gm_d;
    logic [1:0]   round_q, round_d;
    logic [5:0]   frame_q, frame_d;
    logic [7:0]   sec_q, sec_d;
    logic [7:0]   limit;
    logic [5:0]   fr_frame_q, fr_frame_d;
    logic [3:0]   fr_sec_q, fr_sec_d;
    logic [10:0]  combo_q, combo_d;
    logic [11:0]  score_d;
    logic [3:0]   rev_d;
    logic [3:0]   ghost_release;
    ghost_mode_t  mode_q [4];
    ghost_mode_t  mode_d [4];
    ghost_mode_t  target;
    logic         any_fright;
    logic         fright_done;
    logic         flip;

    assign clr_all  = Reset | new_map;
    assign clr_life = soft_reset;

    ghost_release_ctrl u_release (
        .frame_clk     (frame_clk),
        .clr_all       (clr_all),
        .clr_life      (clr_life),
        .level_start   (level_start),
        .pellet_eaten  (pellet_eaten),
        .ghost_release (ghost_release)
    );

    always_comb begin
        any_fright = 1'b0;
        for (int i = 0; i < 4; i++)
            if (mode_q[i] == FRIGHT)
                any_fright = 1'b1;

        gm_d    = gm_q;
        round_d = round_q;
        frame_d = frame_q;
        sec_d   = sec_q;
        limit   = (gm_q == G_CHASE) ? CHASE_S :
                  (round_q < 2'd2)  ? SCAT_S_A : SCAT_S_B;

        if (gm_q == G_WAIT) begin
            if (level_start)
                gm_d = G_SCATTER;
        end else if (!any_fright) begin
            if (frame_q == LAST_FRAME) begin
                frame_d = 6'd0;
                if (sec_q != 8'hFF)
                    sec_d = sec_q + 8'd1;
                // the last round's chase never ends
                if (sec_q == limit - 8'd1 &&
                    !(gm_q == G_CHASE && round_q == 2'd3)) begin
                    gm_d = (gm_q == G_CHASE) ? G_SCATTER : G_CHASE;
                    if (gm_q == G_CHASE)
                        round_d = round_q + 2'd1;
                end
            end else begin
                frame_d = frame_q + 6'd1;
            end
        end

        if (gm_d != gm_q) begin
            frame_d = 6'd0;
            sec_d   = 8'd0;
        end
        flip   = (gm_q != G_WAIT) && (gm_d != gm_q);
        target = (gm_d == G_CHASE) ? CHASE : SCATTER;
    end

    always_comb begin
        fright_done = any_fright && (fr_frame_q == LAST_FRAME) &&
                      (fr_sec_q == FRIGHT_S - 4'd1);
        fr_frame_d  = fr_frame_q;
        fr_sec_d    = fr_sec_q;
        if (power_pellet || fright_done) begin
            fr_frame_d = 6'd0;
            fr_sec_d   = 4'd0;
        end else if (any_fright) begin
            if (fr_frame_q == LAST_FRAME) begin
                fr_frame_d = 6'd0;
                fr_sec_d   = fr_sec_q + 4'd1;
            end else begin
                fr_frame_d = fr_frame_q + 6'd1;
            end
        end
    end

    always_comb begin
        combo_d = combo_q;
        score_d = 12'd0;
        rev_d   = 4'b0;
        for (int i = 0; i < 4; i++) begin
            mode_d[i] = mode_q[i];
            unique case (mode_q[i])
                HOUSE: begin
                    if (ghost_release[i])
                        mode_d[i] = target;
                end
                SCATTER, CHASE: begin
                    mode_d[i] = power_pellet ? FRIGHT : target;
                    rev_d[i]  = power_pellet | flip;
                end
                FRIGHT: begin
                    // scoring walks ghosts in index order
                    if (ghost_eaten[i]) begin
                        mode_d[i] = DEAD;
                        score_d   = score_d + {1'b0, combo_d};
                        combo_d   = (combo_d >= MAX_PTS) ? MAX_PTS :
                                    {combo_d[9:0], 1'b0};
                    end else if (power_pellet) begin
                        rev_d[i] = 1'b1;
                    end else if (fright_done) begin
                        mode_d[i] = target;
                    end
                end
                DEAD: begin
                    if (ghost_home[i])
                        mode_d[i] = target;
                end
                default: mode_d[i] = HOUSE;
            endcase
        end
        if (power_pellet)
            combo_d = BASE_PTS;
    end

    always_ff @(posedge frame_clk) begin
        if (clr_all || clr_life) begin
            gm_q        <= G_WAIT;
            round_q     <= 2'd0;
            frame_q     <= 6'd0;
            sec_q       <= 8'd0;
            fr_frame_q  <= 6'd0;
            fr_sec_q    <= 4'd0;
            combo_q     <= BASE_PTS;
            score_add   <= 12'd0;
            reverse_req <= 4'b0;
            for (int i = 0; i < 4; i++)
                mode_q[i] <= HOUSE;
        end else begin
            gm_q        <= gm_d;
            round_q     <= round_d;
            frame_q     <= frame_d;
            sec_q       <= sec_d;
            fr_frame_q  <= fr_frame_d;
            fr_sec_q    <= fr_sec_d;
            combo_q     <= combo_d;
            score_add   <= score_d;
            reverse_req <= rev_d;
            for (int i = 0; i < 4; i++)
                mode_q[i] <= mode_d[i];
        end
    end

    assign global_mode  = gm_q;
    assign ghost_mode   = {mode_q[3], mode_q[2], mode_q[1], mode_q[0]};
    assign fright_flash = any_fright && (fr_sec_q >= FLASH_S) &&
                          ((fr_frame_q / 6'd10) % 6'd2 == 6'd0);

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: frame-count model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_ghost_mode_scheduler;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b0;
    logic        new_map = 1'b0;
    logic        soft_reset = 1'b0;
    logic        level_start = 1'b0;
    logic        pellet_eaten = 1'b0;
    logic        power_pellet = 1'b0;
    logic [3:0]  ghost_eaten = 4'b0;
    logic [3:0]  ghost_home = 4'b0;
    logic [1:0]  global_mode;
    logic [11:0] ghost_mode;
    logic        fright_flash;
    logic [3:0]  reverse_req;
    logic [11:0] score_add;

    always #5 frame_clk = ~frame_clk;

    ghost_mode_scheduler dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .new_map      (new_map),
        .soft_reset   (soft_reset),
        .level_start  (level_start),
        .pellet_eaten (pellet_eaten),
        .power_pellet (power_pellet),
        .ghost_eaten  (ghost_eaten),
        .ghost_home   (ghost_home),
        .global_mode  (global_mode),
        .ghost_mode   (ghost_mode),
        .fright_flash (fright_flash),
        .reverse_req  (reverse_req),
        .score_add    (score_add)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phases and frightened time tracked as elapsed frame counts
    int m_gm = 0, m_round = 0, m_gel = 0, m_fel = 0;
    int m_combo = 200, m_score = 0, m_dots = 0, m_idle = 0;
    int m_mode [4] = '{0, 0, 0, 0};
    bit m_rev  [4] = '{0, 0, 0, 0};
    bit m_rel  [4] = '{0, 0, 0, 0};
    bit m_started = 0;
    int ngm, tgt, dur, relg, nmd;
    bit anyf, flip, frdone, frc;
    bit ok [4];

    always @(posedge frame_clk) begin
        if (Reset || new_map || soft_reset) begin
            m_gm = 0; m_round = 0; m_gel = 0; m_fel = 0;
            m_combo = 200; m_score = 0; m_idle = 0; m_started = 0;
            for (int i = 0; i < 4; i++) begin
                m_mode[i] = 0; m_rev[i] = 0; m_rel[i] = 0;
            end
            if (Reset || new_map) m_dots = 0;
        end else begin
            anyf = 0;
            for (int i = 0; i < 4; i++) if (m_mode[i] == 3) anyf = 1;
            ngm = m_gm;
            if (m_gm == 0) begin
                if (level_start) begin ngm = 1; m_gel = 0; end
            end else if (!anyf) begin
                if (m_gm == 1) dur = (m_round < 2) ? 420 : 300;
                else           dur = (m_round < 3) ? 1200 : 0;
                m_gel++;
                if (dur != 0 && m_gel == dur) begin
                    ngm = 3 - m_gm;
                    m_gel = 0;
                    if (m_gm == 2) m_round++;
                end
            end
            flip = (m_gm != 0) && (ngm != m_gm);
            tgt  = (ngm == 2) ? 2 : 1;

            ok[0] = m_started || level_start;
            ok[1] = m_started;
            ok[2] = m_started && m_dots >= 30;
            ok[3] = m_started && m_dots >= 60;
            frc = 0;
            if (m_started && !pellet_eaten) begin
                m_idle++;
                if (m_idle == 240) begin frc = 1; m_idle = 0; end
            end else m_idle = 0;
            relg = -1;
            for (int i = 0; i < 4; i++)
                if (relg < 0 && !m_rel[i] && (ok[i] || frc)) relg = i;
            if (relg >= 0) m_rel[relg] = 1;
            if (level_start) m_started = 1;
            if (pellet_eaten && m_dots < 255) m_dots++;

            frdone = anyf && (m_fel == 599);
            if (power_pellet || frdone) m_fel = 0;
            else if (anyf) m_fel++;

            m_score = 0;
            for (int i = 0; i < 4; i++) begin
                m_rev[i] = 0;
                nmd = m_mode[i];
                case (m_mode[i])
                    0: if (relg == i) nmd = tgt;
                    1, 2: begin
                        nmd = power_pellet ? 3 : tgt;
                        m_rev[i] = power_pellet || flip;
                    end
                    3: begin
                        if (ghost_eaten[i]) begin
                            nmd = 4;
                            m_score += m_combo;
                            m_combo = (m_combo * 2 > 1600) ? 1600 : m_combo * 2;
                        end else if (power_pellet) m_rev[i] = 1;
                        else if (frdone) nmd = tgt;
                    end
                    4: if (ghost_home[i]) nmd = tgt;
                    default: nmd = 0;
                endcase
                m_mode[i] = nmd;
            end
            if (power_pellet) m_combo = 200;
            m_gm = ngm;
        end
    end

    int e_modes, e_rev;
    bit e_flash, e_any;
    always @(negedge frame_clk) begin
        if (chk_en) begin
            e_modes = 0; e_rev = 0; e_any = 0;
            for (int i = 0; i < 4; i++) begin
                e_modes |= m_mode[i] << (3 * i);
                e_rev   |= int'(m_rev[i]) << i;
                if (m_mode[i] == 3) e_any = 1;
            end
            e_flash = e_any && m_fel >= 300 && (((m_fel % 60) / 10) % 2 == 0);
            chk("model_global", int'(global_mode), m_gm);
            chk("model_modes", int'(ghost_mode), e_modes);
            chk("model_rev", int'(reverse_req), e_rev);
            chk("model_score", int'(score_add), m_score);
            chk("model_flash", int'(fright_flash), int'(e_flash));
        end
    end

    task automatic cyc(input bit ls, input bit pe, input bit pp,
                       input logic [3:0] ge, input logic [3:0] gh,
                       input bit rs, input bit sr, input bit nm);
        level_start  = ls;
        pellet_eaten = pe;
        power_pellet = pp;
        ghost_eaten  = ge;
        ghost_home   = gh;
        Reset        = rs;
        soft_reset   = sr;
        new_map      = nm;
        @(posedge frame_clk);
        @(negedge frame_clk);
    endtask

    task automatic tick();
        cyc(0, 0, 0, 4'b0, 4'b0, 0, 0, 0);
    endtask

    int exp_len [7] = '{420, 1200, 420, 1200, 300, 1200, 300};
    int ph, cnt, prev;
    bit changed;

    initial begin
        cyc(0, 0, 0, 4'b0, 4'b0, 1, 0, 0);
        chk_en = 1;
        chk("rst_global", int'(global_mode), 0);
        chk("rst_modes", int'(ghost_mode), 0);
        chk("rst_rev", int'(reverse_req), 0);
        chk("rst_score", int'(score_add), 0);
        chk("rst_flash", int'(fright_flash), 0);

        // first scatter, pellets keep the idle timer from releasing Inky
        cyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 0);
        chk("t1_blinky", int'(ghost_mode), 12'h001);
        tick();
        chk("t1_pinky", int'(ghost_mode), 12'h009);
        for (int k = 2; k < 420; k++)
            cyc(0, (k % 100 == 0), 0, 4'b0, 4'b0, 0, 0, 0);
        chk("t1_scatter_end", int'(global_mode), 1);
        tick();
        chk("t1_chase", int'(global_mode), 2);
        chk("t1_rev", int'(reverse_req), 4'b0011);
        chk("t1_modes", int'(ghost_mode), 12'h012);
        tick();
        chk("t1_rev_pulse", int'(reverse_req), 0);

        // full timetable
        cyc(0, 0, 0, 4'b0, 4'b0, 1, 0, 0);
        cyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 0);
        ph = 0; cnt = 0; prev = int'(global_mode);
        for (int n = 0; n < 6000 && ph < 7; n++) begin
            tick();
            cnt++;
            if (int'(global_mode) != prev) begin
                chk($sformatf("t2_phase%0d_len", ph), cnt, exp_len[ph]);
                ph++; cnt = 0; prev = int'(global_mode);
            end
        end
        chk("t2_phases_seen", ph, 7);
        chk("t2_round3_chase", int'(global_mode), 2);
        changed = 0;
        repeat (18060) begin
            tick();
            if (global_mode != 2'd2) changed = 1;
        end
        chk("t2_chase_persists", int'(changed), 0);

        // power pellet at chase second 10
        cyc(0, 0, 0, 4'b0, 4'b0, 1, 0, 0);
        cyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 0);
        repeat (420) tick();
        chk("t3_chase", int'(global_mode), 2);
        repeat (600) tick();
        chk("t3_all_chase", int'(ghost_mode), 12'h492);
        cyc(0, 0, 1, 4'b0, 4'b0, 0, 0, 0);
        chk("t3_fright", int'(ghost_mode), 12'h6DB);
        chk("t3_rev", int'(reverse_req), 4'hF);
        repeat (299) tick();
        chk("t3_noflash", int'(fright_flash), 0);
        tick();
        chk("t3_flash", int'(fright_flash), 1);
        repeat (299) tick();
        chk("t3_still_fright", int'(ghost_mode), 12'h6DB);
        tick();
        chk("t3_back_chase", int'(ghost_mode), 12'h492);
        repeat (598) tick();
        chk("t3_chase_left", int'(global_mode), 2);
        tick();
        chk("t3_scatter", int'(global_mode), 1);

        // eat all four in turn
        cyc(0, 0, 1, 4'b0, 4'b0, 0, 0, 0);
        chk("t4_fright", int'(ghost_mode), 12'h6DB);
        cyc(0, 0, 0, 4'b0001, 4'b0, 0, 0, 0);
        chk("t4_eat0", int'(score_add), 200);
        chk("t4_g0_dead", int'(ghost_mode), 12'h6DC);
        cyc(0, 0, 0, 4'b0010, 4'b0, 0, 0, 0);
        chk("t4_eat1", int'(score_add), 400);
        cyc(0, 0, 0, 4'b0100, 4'b0, 0, 0, 0);
        chk("t4_eat2", int'(score_add), 800);
        cyc(0, 0, 0, 4'b1000, 4'b0, 0, 0, 0);
        chk("t4_eat3", int'(score_add), 1600);
        chk("t4_all_dead", int'(ghost_mode), 12'h924);
        tick();
        chk("t4_no_score", int'(score_add), 0);
        cyc(0, 0, 0, 4'b0, 4'b0001, 0, 0, 0);
        chk("t4_g0_home", int'(ghost_mode), 12'h921);

        // double eat together with a fresh power pellet
        cyc(0, 0, 0, 4'b0, 4'b1110, 0, 0, 0);
        chk("t5_all_home", int'(ghost_mode), 12'h249);
        cyc(0, 0, 1, 4'b0, 4'b0, 0, 0, 0);
        cyc(0, 0, 1, 4'b0011, 4'b0, 0, 0, 0);
        chk("t5_score", int'(score_add), 600);
        chk("t5_modes", int'(ghost_mode), 12'h6E4);
        cyc(0, 0, 0, 4'b0100, 4'b0, 0, 0, 0);
        chk("t5_combo_reset", int'(score_add), 200);
        chk("t5_g2_dead", int'(ghost_mode), 12'h724);

        // dot and idle releases, then soft reset keeps dots
        cyc(0, 0, 0, 4'b0, 4'b0, 0, 0, 1);
        chk("t6_newmap", int'(ghost_mode), 0);
        cyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 0);
        for (int k = 0; k < 30; k++)
            cyc(0, 1, 0, 4'b0, 4'b0, 0, 0, 0);
        chk("t6_inky_wait", int'(ghost_mode), 12'h009);
        tick();
        chk("t6_inky_out", int'(ghost_mode), 12'h049);
        repeat (238) tick();
        chk("t6_clyde_wait", int'(ghost_mode), 12'h049);
        tick();
        chk("t6_clyde_out", int'(ghost_mode), 12'h249);
        cyc(0, 0, 0, 4'b0, 4'b0, 0, 1, 0);
        chk("t6_soft_modes", int'(ghost_mode), 0);
        chk("t6_soft_global", int'(global_mode), 0);
        cyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 0);
        tick();
        tick();
        chk("t6_dots_kept", int'(ghost_mode), 12'h049);
        cyc(0, 0, 0, 4'b0, 4'b0, 0, 0, 1);
        cyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 0);
        tick();
        tick();
        chk("t6_dots_cleared", int'(ghost_mode), 12'h009);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
